ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_line_filter.sv | 59 +++++
 rtl/ps2_host_tx.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, command bytes,
// keyboard scan codes used by the receiver, and default timing values.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;

    localparam logic [7:0] BREAK = 8'hF0;
    localparam logic [7:0] UP    = 8'h75;
    localparam logic [7:0] LEFT  = 8'h6B;
    localparam logic [7:0] DOWN  = 8'h72;
    localparam logic [7:0] RIGHT = 8'h74;

    localparam int unsigned DEF_INHIBIT_CYCLES    = 5000;
    localparam int unsigned DEF_START_HOLD_CYCLES = 50;
    localparam int unsigned DEF_TIMEOUT_CYCLES    = 750000;
    localparam int unsigned DEF_FILTER_LEN        = 8;
    localparam int unsigned DEF_MAX_RETRIES       = 2;

    // Bits shifted out after the start bit, LSB first: data, odd parity, stop.
    function automatic logic [9:0] ps2_tx_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-flop synchronizers on clock and data, a
// FILTER_LEN-sample debounce on the clock and a filtered falling-edge pulse.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_in,
    input  logic ps2_dat_in,
    output logic clk_filt,
    output logic clk_fe,
    output logic dat_sync
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic          filt_q, filt_d;
    logic          fe_q, fe_d;
    logic [FW-1:0] cnt_q, cnt_d;

    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk_in};
        dat_sync_d = {dat_sync_q[0], ps2_dat_in};
        filt_d     = filt_q;
        cnt_d      = '0;
        // Level flips only after FILTER_LEN consecutive samples disagree with it.
        if (clk_sync_q[1] != filt_q) begin
            if (cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                cnt_d = cnt_q + FW'(1);
            end
        end
        fe_d = filt_q & ~filt_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            filt_q     <= 1'b1;
            fe_q       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            filt_q     <= filt_d;
            fe_q       <= fe_d;
            cnt_q      <= cnt_d;
        end
    end

    assign clk_filt = filt_q;
    assign clk_fe   = fe_q;
    assign dat_sync = dat_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter with open-drain output enables.
// Optional automatic retry on failure is enabled by defining PS2_TX_RETRY_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES    = DEF_INHIBIT_CYCLES,
    parameter int unsigned START_HOLD_CYCLES = DEF_START_HOLD_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES,
    parameter int unsigned FILTER_LEN        = DEF_FILTER_LEN,
    parameter int unsigned MAX_RETRIES       = DEF_MAX_RETRIES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send_valid,
    input  logic [7:0] send_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       send_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned PHASE_MAX = (INHIBIT_CYCLES > START_HOLD_CYCLES) ?
                                        INHIBIT_CYCLES : START_HOLD_CYCLES;
    localparam int unsigned PW = $clog2(PHASE_MAX + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RW = $clog2(MAX_RETRIES + 2);
`ifdef PS2_TX_RETRY_EN
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);
`else
    localparam logic [RW-1:0] RETRY_LIMIT = '0;
`endif

    logic clk_filt;
    logic clk_fe;
    logic dat_sync;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .clk_filt  (clk_filt),
        .clk_fe    (clk_fe),
        .dat_sync  (dat_sync)
    );

    ps2_tx_state_e state_q, state_d;
    logic [9:0]    frame_q, frame_d;
    logic [3:0]    idx_q, idx_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          ack_ok_q, ack_ok_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          fail;

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        idx_d    = idx_q;
        phase_d  = phase_q;
        to_cnt_d = to_cnt_q;
        retry_d  = retry_q;
        ack_ok_d = ack_ok_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        fail     = 1'b0;

        case (state_q)
            IDLE: begin
                if (send_valid && ready_q) begin
                    frame_d  = ps2_tx_frame(send_data);
                    retry_d  = '0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    clk_oe_d = 1'b1;
                    phase_d  = '0;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                phase_d = phase_q + PW'(1);
                if (phase_q == PW'(INHIBIT_CYCLES - 1)) begin
                    dat_oe_d = 1'b1;
                    phase_d  = '0;
                    state_d  = START;
                end
            end
            START: begin
                phase_d = phase_q + PW'(1);
                if (phase_q == PW'(START_HOLD_CYCLES - 1)) begin
                    clk_oe_d = 1'b0;
                    to_cnt_d = '0;
                    idx_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (clk_fe) begin
                    dat_oe_d = ~frame_q[idx_q];
                    idx_d    = idx_q + 4'd1;
                    if (idx_q == 4'd9) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (clk_fe) begin
                    ack_ok_d = ~dat_sync;
                    state_d  = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_filt && dat_sync) begin
                    if (ack_ok_q) begin
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q inside {SHIFT, ACK, WAIT_IDLE}) begin
            to_cnt_d = to_cnt_q + TW'(1);
            if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                fail = 1'b1;
            end
        end

        // A timeout overrides a completion landing in the same cycle.
        if (fail) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            done_d   = 1'b0;
            phase_d  = '0;
            if (retry_q != RETRY_LIMIT) begin
                retry_d  = retry_q + RW'(1);
                clk_oe_d = 1'b1;
                state_d  = INHIBIT;
            end else begin
                err_d   = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            frame_q  <= '0;
            idx_q    <= '0;
            phase_q  <= '0;
            to_cnt_q <= '0;
            retry_q  <= '0;
            ack_ok_q <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            to_cnt_q <= to_cnt_d;
            retry_q  <= retry_d;
            ack_ok_q <= ack_ok_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign send_ready = ready_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign tx_error   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-drain PS/2 device model.
// Works with or without PS2_TX_RETRY_EN defined.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int H       = 60;    // device clock half period in system cycles
    localparam int TIMEOUT = 4000;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       send_valid = 1'b0;
    logic [7:0] send_data = '0;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       send_ready, tx_busy, tx_done, tx_error;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    int total = 0;
    int bad = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, inhibit_cnt = 0;
    logic clk_oe_prev = 1'b0;

    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    always #10 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES   (5000),
        .START_HOLD_CYCLES(50),
        .TIMEOUT_CYCLES   (TIMEOUT),
        .FILTER_LEN       (8),
        .MAX_RETRIES      (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .send_valid(send_valid),
        .send_data (send_data),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .send_ready(send_ready),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error)
    );

    always @(posedge clk) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_error) err_cnt <= err_cnt + 1;
        if (tx_done && tx_error) both_cnt <= both_cnt + 1;
        if (ps2_clk_oe && !clk_oe_prev) inhibit_cnt <= inhibit_cnt + 1;
        clk_oe_prev <= ps2_clk_oe;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        send_data  = b;
        send_valid = 1'b1;
        tick(1);
        send_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!(ps2_dat_oe && !ps2_clk_oe) && n < 8000) begin
            tick(1);
            n++;
        end
        chk(tag, {31'd0, ps2_dat_oe & ~ps2_clk_oe}, 32'd1);
    endtask

    task automatic wait_pulse();
        int n = 0;
        while (!(tx_done || tx_error) && n < 500) begin
            tick(1);
            n++;
        end
        tick(2);
    endtask

    // Device side: samples start before the first fall, then each bit on the rising edge.
    task automatic device(input bit ack, input int abort_fe, input int glitch_k,
                          output logic [10:0] s);
        s    = '0;
        s[0] = ps2_dat_in;
        tick(H);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack) begin
                dev_dat_low = 1'b1;
                tick(10);
            end
            dev_clk_low = 1'b1;
            tick(H);
            if (k == abort_fe) return;
            dev_clk_low = 1'b0;
            if (k <= 10) s[k] = ps2_dat_in;
            if (k == glitch_k) begin
                tick(H / 2);
                dev_clk_low = 1'b1;
                tick(3);
                dev_clk_low = 1'b0;
                tick(H - H / 2 - 3);
            end else begin
                tick(H);
            end
            if (k == 11) dev_dat_low = 1'b0;
        end
    endtask

    initial begin
        logic [10:0] s;
        int d0, e0, i0, n, m;
        logic clk_oe_held;

        // Reset state
        tick(3);
        @(negedge clk) reset = 1'b0;
        tick(1);
        chk("rst clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        chk("rst dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        chk("rst ready", {31'd0, send_ready}, 32'd1);
        chk("rst busy", {31'd0, tx_busy}, 32'd0);
        chk("rst done", {31'd0, tx_done}, 32'd0);
        chk("rst error", {31'd0, tx_error}, 32'd0);

        // 0xED with ACK; a request while busy must be ignored
        d0 = done_cnt; e0 = err_cnt;
        send(CMD_SET_LEDS);
        chk("ed ready", {31'd0, send_ready}, 32'd0);
        chk("ed busy", {31'd0, tx_busy}, 32'd1);
        tick(100);
        send(8'h00);
        wait_req("ed req");
        device(1'b1, 0, 0, s);
        chk("ed bits", {21'd0, s}, {21'd0, 11'b11111011010});
        wait_pulse();
        chk("ed done", done_cnt - d0, 1);
        chk("ed error", err_cnt - e0, 0);
        chk("ed idle busy", {31'd0, tx_busy}, 32'd0);
        chk("ed idle ready", {31'd0, send_ready}, 32'd1);

        // 0xFF: inhibit/start timing and parity
        d0 = done_cnt;
        send(CMD_RESET);
        n = 0; clk_oe_held = 1'b1;
        while (!ps2_dat_oe && n < 6000) begin
            tick(1);
            n++;
            clk_oe_held &= ps2_clk_oe;
        end
        chk("ff inhibit cycles", n, 5000);
        chk("ff clk held", {31'd0, clk_oe_held}, 32'd1);
        m = 0;
        while (ps2_clk_oe && m < 200) begin
            tick(1);
            m++;
        end
        chk("ff start hold", m, 50);
        device(1'b1, 0, 0, s);
        chk("ff bits", {21'd0, s}, {21'd0, 11'b11111111110});
        chk("ff parity", {31'd0, s[9]}, 32'd1);
        wait_pulse();
        chk("ff done", done_cnt - d0, 1);

        // No ACK from the device
        d0 = done_cnt; e0 = err_cnt; i0 = inhibit_cnt;
        send(CMD_ECHO);
        for (int a = 0; a < ATTEMPTS; a++) begin
            wait_req("noack req");
            device(1'b0, 0, 0, s);
            chk("noack bits", {21'd0, s}, {21'd0, 11'b11111011100});
        end
        wait_pulse();
        chk("noack error", err_cnt - e0, 1);
        chk("noack done", done_cnt - d0, 0);
        chk("noack inhibits", inhibit_cnt - i0, ATTEMPTS);
        chk("noack ready", {31'd0, send_ready}, 32'd1);

        // Device never clocks
        e0 = err_cnt;
        send(CMD_RESET);
        for (int a = 0; a < ATTEMPTS; a++) begin
            wait_req("to req");
            n = 0;
            while (!(tx_error || ps2_clk_oe) && n < 6000) begin
                tick(1);
                n++;
            end
            chk("to cycles", n, TIMEOUT);
            chk("to oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, (a == ATTEMPTS - 1) ? 32'd0 : 32'd2);
            chk("to error", {31'd0, tx_error}, (a == ATTEMPTS - 1) ? 32'd1 : 32'd0);
        end
        tick(2);
        chk("to error count", err_cnt - e0, 1);

        // Asynchronous reset after the 4th falling edge
        send(BREAK);
        wait_req("rst req");
        device(1'b1, 4, 0, s);
        chk("mid dat_oe before", {31'd0, ps2_dat_oe}, {31'd0, ~s[3]});
        d0 = done_cnt; e0 = err_cnt;
        #3 reset = 1'b1;
        #1;
        chk("mid rst oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        tick(3);
        @(negedge clk) reset = 1'b0;
        tick(1);
        chk("mid rst ready", {31'd0, send_ready}, 32'd1);
        chk("mid rst busy", {31'd0, tx_busy}, 32'd0);
        tick(50);
        chk("mid rst pulses", (done_cnt - d0) + (err_cnt - e0), 0);

        // Short clock glitch during SHIFT is filtered out
        d0 = done_cnt; e0 = err_cnt;
        send(8'h5A);
        wait_req("gl req");
        device(1'b1, 0, 4, s);
        chk("gl bits", {21'd0, s}, {21'd0, 11'b11010110100});
        wait_pulse();
        chk("gl done", done_cnt - d0, 1);
        chk("gl error", err_cnt - e0, 0);

        chk("done/error exclusive", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
